bck_token_store: RTL and testbench
==================================

# bck_token_store

Storage unit for the backward-extension pipeline. It holds two 128-entry token banks: the current bank is written via `store_valid_curr`/`curr_x_*`, and the memory bank via `store_valid_mem`/`mem_x_*`. Both write streams come from the first backward control stage. The block serves the stage's read-back requests on `current_rd_addr`, and at iteration end it drains the memory bank in address order to the result writer. While draining it asserts `stall` back to the pipeline.

## Interface
Parameters
- `DEPTH`, 128: entries per bank.
- `ADDR_W`, 7: address width; DEPTH = 2^ADDR_W.

Ports
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `status_in`  in  6  pipeline status code (BUBBLE/BCK_INI/BCK_RUN).
- `read_num_in`  in  `READ_NUM_WIDTH`  read tag of the incoming token.
- `store_valid_curr`  in  1  current-bank write enable.
- `curr_x_0`/`curr_x_1`/`curr_x_2`/`curr_x_info`  in  64 each  current-bank write data.
- `curr_x_addr`  in  7  current-bank write address.
- `store_valid_mem`  in  1  memory-bank write enable.
- `mem_x_0`/`mem_x_1`/`mem_x_2`/`mem_x_info`  in  64 each  memory-bank write data.
- `mem_x_addr`  in  7  memory-bank write address.
- `rd_en`  in  1  current-bank read request.
- `rd_addr`  in  7  current-bank read address.
- `rd_valid`  out  1  read data valid, one cycle after `rd_en`.
- `rd_hit`  out  1  addressed entry was written since the last clear.
- `rd_x0`/`rd_x1`/`rd_x2`/`rd_info`  out  64 each  read data.
- `drain_start`  in  1  begin draining the memory bank.
- `drain_count`  in  7  number of entries to drain (stage's `mem_wr_addr`).
- `out_valid`  out  1  drain beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_x0`/`out_x1`/`out_x2`/`out_info`  out  64 each  drain beat data.
- `out_read_num`  out  `READ_NUM_WIDTH`  read tag latched at `drain_start`.
- `out_last`  out  1  final beat marker.
- `drain_done`  out  1  one-cycle pulse at drain completion.
- `stall`  out  1  hold request to the pipeline.

## Operation
- **Banks.** Each bank is DEPTH × 256 bits held in flops, with a per-entry valid bitmap.
- **Writes.** A write occurs on a rising clock edge when its enable is high. The entry stores {x0, x1, x2, info} and its valid bit is set. Both banks may write in the same cycle.
- **Clear.** When `status_in`==BCK_INI, both valid bitmaps are cleared in one cycle; data is not cleared. If a write coincides with the clear, the written entry ends valid.
- **Reads.**
  - `rd_en` registers the current-bank entry at `rd_addr` into `rd_*`.
  - Forwarding: if `store_valid_curr` is high with `curr_x_addr`==`rd_addr` in the same cycle, the write data and `rd_hit`=1 are returned instead of the array contents.
  - An unwritten entry returns stale data with `rd_hit`=0.
- **Drain FSM.** States are IDLE, DRAIN, DONE.
  - IDLE→DRAIN on `drain_start` with `drain_count`≠0. This latches the count and `read_num_in` and sets the index to 0.
  - IDLE→DONE on `drain_start` with `drain_count`==0. No beats are produced.
  - DRAIN: `out_*` always presents the memory-bank entry at the current index. On `out_valid`&&`out_ready` the index increments. `out_last` is high when index==count−1. A handshake on the last beat goes to DONE.
  - DONE: `drain_done`=1 for one cycle, then IDLE.
  - `drain_start` received outside IDLE is ignored.
- **Stall.** `stall` = (state≠IDLE) || `drain_start`, so the pipeline holds from the request cycle onward.
- **Writes during a stall.** These are accepted. Upstream holds its registered write outputs, so repeated writes are idempotent.
- **Index width.** The index is 7-bit and never wraps: count ≤ 127 by construction.

## Timing
- Reset (asynchronous): state=IDLE; both bitmaps cleared; `rd_valid`, `rd_hit`, `out_valid`, `out_last`, `drain_done`, `stall` = 0; `rd_*`, `out_*`, `out_read_num` = 0.
- Write to read-visible: a write is visible to the next cycle's `rd_en`. A same-cycle write is visible via forwarding.
- Read latency: 1 cycle. `rd_valid` is `rd_en` delayed by one cycle.
- Drain latency:
  - The first beat has `out_valid`=1 in the cycle after `drain_start`.
  - Throughput is one beat per cycle while `out_ready` is high.
  - `drain_done` pulses the cycle after the last handshake.
- Back-pressure: when `out_ready` is low, `out_*` holds stable.
- A write to the memory-bank address currently being presented updates `out_*` on the next cycle. The upstream stage is stalled, so the written data is identical.

## Structure
- Status codes BUBBLE/BCK_INI/BCK_RUN and `READ_NUM_WIDTH` come from the shared pipeline header/package. Add `TOKEN_W`=256 and the drain-state encoding there.
- One sub-module, `token_bank`: a single bank with write port, valid bitmap, clear, and combinational read mux. It is instantiated twice. The drain FSM and read register stay in the top level.

## Test plan
- **Write then read.** Write curr addr 5 with x2=0x1234; next cycle `rd_en` addr 5. Required: `rd_valid`=1, `rd_x2`=0x1234, `rd_hit`=1.
- **Forwarding and clear.** Same-cycle write plus read of curr addr 9. Required: forwarded data with `rd_hit`=1. Then apply BCK_INI and read addr 9. Required: `rd_hit`=0.
- **Drain at full rate.** Write mem addrs 0–2, then `drain_start` with count=3 and `out_ready`=1. Required: three consecutive beats with addrs 0, 1, 2; `out_last` on the third beat; `drain_done` one cycle later; `stall` high from the start cycle through the done cycle.
- **Back-pressure.** Drain count=2 with `out_ready` low for 3 cycles on the first beat. Required: beat 0 held stable for 3 cycles, then both beats delivered.
- **Empty drain.** `drain_start` with count=0. Required: no `out_valid`; `drain_done` one cycle later.
- **Reset mid-drain.** Assert `rst` during beat 1 of a count=4 drain. Required: outputs at reset values immediately; state IDLE; valid bitmaps cleared.

Source files
------------

// File: rtl/bck_token_store_pkg.sv
// Shared definitions for the backward-extension token store.
// Status codes, token layout and drain-state encoding.
package bck_token_store_pkg;

  localparam int READ_NUM_WIDTH = 32;
  localparam int TOKEN_W = 256;

  localparam logic [5:0] BUBBLE  = 6'd0;
  localparam logic [5:0] BCK_INI = 6'd1;
  localparam logic [5:0] BCK_RUN = 6'd2;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] info;
  } token_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/bck_token_store_token_bank.sv
// One token bank: flop array, per-entry valid bitmap,
// single-cycle bitmap clear and combinational read mux.
module token_bank
  import bck_token_store_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  token_t            wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output token_t            rdata_o,
  output logic              rhit_o
);

  token_t           data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Token payload storage; contents survive clear and reset.
  always_ff @(posedge clk) begin
    if (we_i) data_q[waddr_i] <= wdata_i;
  end

  // Clear wipes the bitmap, a coinciding write still lands valid.
  always_comb begin
    valid_d = clr_i ? '0 : valid_q;
    if (we_i) valid_d[waddr_i] = 1'b1;
  end

  // Valid bitmap register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  assign rdata_o = data_q[raddr_i];
  assign rhit_o  = valid_q[raddr_i];

endmodule

// File: rtl/bck_token_store.sv
// Current/memory token banks with read-back port and an
// in-order memory-bank drain to the result writer.
module bck_token_store
  import bck_token_store_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                status_in,
  input  logic [READ_NUM_WIDTH-1:0] read_num_in,
  input  logic                      store_valid_curr,
  input  logic [63:0]               curr_x_0,
  input  logic [63:0]               curr_x_1,
  input  logic [63:0]               curr_x_2,
  input  logic [63:0]               curr_x_info,
  input  logic [ADDR_W-1:0]         curr_x_addr,
  input  logic                      store_valid_mem,
  input  logic [63:0]               mem_x_0,
  input  logic [63:0]               mem_x_1,
  input  logic [63:0]               mem_x_2,
  input  logic [63:0]               mem_x_info,
  input  logic [ADDR_W-1:0]         mem_x_addr,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic                      rd_valid,
  output logic                      rd_hit,
  output logic [63:0]               rd_x0,
  output logic [63:0]               rd_x1,
  output logic [63:0]               rd_x2,
  output logic [63:0]               rd_info,
  input  logic                      drain_start,
  input  logic [ADDR_W-1:0]         drain_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [63:0]               out_x0,
  output logic [63:0]               out_x1,
  output logic [63:0]               out_x2,
  output logic [63:0]               out_info,
  output logic [READ_NUM_WIDTH-1:0] out_read_num,
  output logic                      out_last,
  output logic                      drain_done,
  output logic                      stall
);

  logic   clr;
  token_t curr_wr;
  token_t mem_wr;
  token_t curr_rd;
  token_t mem_rd;
  logic   curr_hit;
  logic   mem_hit_unused;
  logic   fwd;

  assign clr     = (status_in == BCK_INI);
  assign curr_wr = '{curr_x_0, curr_x_1, curr_x_2, curr_x_info};
  assign mem_wr  = '{mem_x_0, mem_x_1, mem_x_2, mem_x_info};

  drain_state_e              state_q, state_d;
  logic [ADDR_W-1:0]         idx_q, idx_d;
  logic [ADDR_W-1:0]         cnt_q, cnt_d;
  logic [READ_NUM_WIDTH-1:0] rnum_q, rnum_d;

  token_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_curr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .we_i    (store_valid_curr),
    .waddr_i (curr_x_addr),
    .wdata_i (curr_wr),
    .raddr_i (rd_addr),
    .rdata_o (curr_rd),
    .rhit_o  (curr_hit)
  );

  token_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .we_i    (store_valid_mem),
    .waddr_i (mem_x_addr),
    .wdata_i (mem_wr),
    .raddr_i (idx_q),
    .rdata_o (mem_rd),
    .rhit_o  (mem_hit_unused)
  );

  assign fwd = store_valid_curr && (curr_x_addr == rd_addr);

  logic   rd_valid_q;
  logic   rd_hit_q;
  token_t rd_data_q;

  // Read-back register; same-cycle writes bypass the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= fwd ? curr_wr : curr_rd;
        rd_hit_q  <= fwd | curr_hit;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_hit   = rd_hit_q;
  assign rd_x0    = rd_data_q.x0;
  assign rd_x1    = rd_data_q.x1;
  assign rd_x2    = rd_data_q.x2;
  assign rd_info  = rd_data_q.info;

  // Drain state, index, count and latched read tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      rnum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rnum_q  <= rnum_d;
    end
  end

  // Drain sequencing: start, per-beat advance, done pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rnum_d  = rnum_q;
    unique case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          if (drain_count != '0) begin
            state_d = ST_DRAIN;
            cnt_d   = drain_count;
            rnum_d  = read_num_in;
            idx_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (out_last) state_d = ST_DONE;
          else          idx_d   = idx_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign out_valid    = (state_q == ST_DRAIN);
  assign out_last     = out_valid && (idx_q == cnt_q - 1'b1);
  assign drain_done   = (state_q == ST_DONE);
  assign stall        = (state_q != ST_IDLE) || drain_start;
  assign out_read_num = rnum_q;
  assign out_x0       = out_valid ? mem_rd.x0   : '0;
  assign out_x1       = out_valid ? mem_rd.x1   : '0;
  assign out_x2       = out_valid ? mem_rd.x2   : '0;
  assign out_info     = out_valid ? mem_rd.info : '0;

endmodule

// File: tb/tb_bck_token_store.sv
// Bench for bck_token_store: reference model with per-cycle
// comparison plus directed scenarios with literal expectations.
module tb_bck_token_store;
  import bck_token_store_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] status_in = BUBBLE;
  logic [READ_NUM_WIDTH-1:0] read_num_in = '0;
  logic store_valid_curr = 1'b0;
  logic [63:0] curr_x_0 = '0, curr_x_1 = '0, curr_x_2 = '0, curr_x_info = '0;
  logic [6:0] curr_x_addr = '0;
  logic store_valid_mem = 1'b0;
  logic [63:0] mem_x_0 = '0, mem_x_1 = '0, mem_x_2 = '0, mem_x_info = '0;
  logic [6:0] mem_x_addr = '0;
  logic rd_en = 1'b0;
  logic [6:0] rd_addr = '0;
  logic rd_valid, rd_hit;
  logic [63:0] rd_x0, rd_x1, rd_x2, rd_info;
  logic drain_start = 1'b0;
  logic [6:0] drain_count = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [63:0] out_x0, out_x1, out_x2, out_info;
  logic [READ_NUM_WIDTH-1:0] out_read_num;
  logic out_last, drain_done, stall;

  int total = 0;
  int bad = 0;

  bck_token_store dut (
    .clk(clk), .rst(rst), .status_in(status_in),
    .read_num_in(read_num_in),
    .store_valid_curr(store_valid_curr),
    .curr_x_0(curr_x_0), .curr_x_1(curr_x_1),
    .curr_x_2(curr_x_2), .curr_x_info(curr_x_info),
    .curr_x_addr(curr_x_addr),
    .store_valid_mem(store_valid_mem),
    .mem_x_0(mem_x_0), .mem_x_1(mem_x_1),
    .mem_x_2(mem_x_2), .mem_x_info(mem_x_info),
    .mem_x_addr(mem_x_addr),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_hit(rd_hit),
    .rd_x0(rd_x0), .rd_x1(rd_x1), .rd_x2(rd_x2), .rd_info(rd_info),
    .drain_start(drain_start), .drain_count(drain_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x0(out_x0), .out_x1(out_x1), .out_x2(out_x2), .out_info(out_info),
    .out_read_num(out_read_num), .out_last(out_last),
    .drain_done(drain_done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: arrays of tokens, a queue of pending drain addresses.
  logic [255:0] cd [128];
  logic [255:0] md [128];
  bit cv [128];
  bit mv [128];
  int q[$];
  bit e_done;
  logic [READ_NUM_WIDTH-1:0] e_rnum;
  bit e_rv, e_rh;
  logic [255:0] e_rd;

  always @(posedge clk or posedge rst) begin : model
    bit idle;
    if (rst) begin
      for (int i = 0; i < 128; i++) begin
        cv[i] = 0;
        mv[i] = 0;
      end
      q.delete();
      e_done = 0;
      e_rnum = '0;
      e_rv = 0;
      e_rh = 0;
      e_rd = '0;
    end else begin
      idle = (q.size() == 0) && !e_done;
      e_done = 0;
      if (q.size() != 0) begin
        if (out_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) e_done = 1;
        end
      end else if (idle && drain_start) begin
        if (drain_count == 0) e_done = 1;
        else begin
          e_rnum = read_num_in;
          for (int i = 0; i < int'(drain_count); i++) q.push_back(i);
        end
      end
      e_rv = rd_en;
      if (rd_en) begin
        if (store_valid_curr && curr_x_addr == rd_addr) begin
          e_rd = {curr_x_0, curr_x_1, curr_x_2, curr_x_info};
          e_rh = 1;
        end else begin
          e_rd = cd[rd_addr];
          e_rh = cv[rd_addr];
        end
      end
      if (status_in == BCK_INI)
        for (int i = 0; i < 128; i++) begin
          cv[i] = 0;
          mv[i] = 0;
        end
      if (store_valid_curr) begin
        cd[curr_x_addr] = {curr_x_0, curr_x_1, curr_x_2, curr_x_info};
        cv[curr_x_addr] = 1;
      end
      if (store_valid_mem) begin
        md[mem_x_addr] = {mem_x_0, mem_x_1, mem_x_2, mem_x_info};
        mv[mem_x_addr] = 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    logic [255:0] t;
    if (!rst) begin
      check("m_stall", 64'(stall),
            64'((q.size() != 0) || e_done || drain_start));
      check("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("m_out_last", 64'(out_last), 64'(q.size() == 1));
      check("m_drain_done", 64'(drain_done), 64'(e_done));
      check("m_read_num", 64'(out_read_num), 64'(e_rnum));
      if (q.size() != 0 && mv[q[0]]) begin
        t = md[q[0]];
        check("m_out_x0", out_x0, t[255:192]);
        check("m_out_x1", out_x1, t[191:128]);
        check("m_out_x2", out_x2, t[127:64]);
        check("m_out_info", out_info, t[63:0]);
      end
      check("m_rd_valid", 64'(rd_valid), 64'(e_rv));
      if (e_rv) begin
        check("m_rd_hit", 64'(rd_hit), 64'(e_rh));
        if (e_rh) begin
          check("m_rd_x0", rd_x0, e_rd[255:192]);
          check("m_rd_x1", rd_x1, e_rd[191:128]);
          check("m_rd_x2", rd_x2, e_rd[127:64]);
          check("m_rd_info", rd_info, e_rd[63:0]);
        end
      end
    end
  end

  task automatic wr_mem(input int a, input logic [63:0] v);
    store_valid_mem = 1'b1;
    mem_x_addr = 7'(a);
    mem_x_0 = v;
    mem_x_1 = v ^ 64'hFFFF;
    mem_x_2 = v + 64'd7;
    mem_x_info = {32'hC0DE, v[31:0]};
    cyc();
    store_valid_mem = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_x0", rd_x0, 64'd0);
    check("rst_out_x0", out_x0, 64'd0);
    check("rst_done", 64'(drain_done), 64'd0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // write then read
    store_valid_curr = 1'b1;
    curr_x_addr = 7'd5;
    curr_x_0 = 64'h11;
    curr_x_1 = 64'h22;
    curr_x_2 = 64'h1234;
    curr_x_info = 64'h55;
    cyc();
    store_valid_curr = 1'b0;
    rd_en = 1'b1;
    rd_addr = 7'd5;
    cyc();
    rd_en = 1'b0;
    check("wr_rd_valid", 64'(rd_valid), 64'd1);
    check("wr_rd_x2", rd_x2, 64'h1234);
    check("wr_rd_hit", 64'(rd_hit), 64'd1);

    // forwarding, then clear
    store_valid_curr = 1'b1;
    curr_x_addr = 7'd9;
    curr_x_0 = 64'hAAAA;
    rd_en = 1'b1;
    rd_addr = 7'd9;
    cyc();
    store_valid_curr = 1'b0;
    rd_en = 1'b0;
    check("fwd_x0", rd_x0, 64'hAAAA);
    check("fwd_hit", 64'(rd_hit), 64'd1);
    status_in = BCK_INI;
    cyc();
    status_in = BCK_RUN;
    rd_en = 1'b1;
    rd_addr = 7'd9;
    cyc();
    rd_en = 1'b0;
    check("clr_hit", 64'(rd_hit), 64'd0);

    // full-rate drain
    for (int i = 0; i < 3; i++) wr_mem(i, 64'h100 + 64'(i));
    drain_start = 1'b1;
    drain_count = 7'd3;
    read_num_in = 32'h5A;
    out_ready = 1'b1;
    #1;
    check("fr_stall_req", 64'(stall), 64'd1);
    cyc();
    drain_start = 1'b0;
    check("fr_b0", out_x0, 64'h100);
    check("fr_b0_last", 64'(out_last), 64'd0);
    check("fr_tag", 64'(out_read_num), 64'h5A);
    cyc();
    check("fr_b1", out_x0, 64'h101);
    cyc();
    check("fr_b2", out_x0, 64'h102);
    check("fr_b2_last", 64'(out_last), 64'd1);
    cyc();
    check("fr_done", 64'(drain_done), 64'd1);
    check("fr_done_stall", 64'(stall), 64'd1);
    cyc();
    check("fr_idle_stall", 64'(stall), 64'd0);
    check("fr_done_end", 64'(drain_done), 64'd0);

    // back-pressure
    wr_mem(0, 64'h200);
    wr_mem(1, 64'h201);
    drain_start = 1'b1;
    drain_count = 7'd2;
    out_ready = 1'b0;
    cyc();
    drain_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", out_x0, 64'h200);
      if (i < 2) cyc();
    end
    out_ready = 1'b1;
    cyc();
    check("bp_b1", out_x0, 64'h201);
    check("bp_b1_last", 64'(out_last), 64'd1);
    cyc();
    check("bp_done", 64'(drain_done), 64'd1);
    cyc();

    // empty drain
    drain_start = 1'b1;
    drain_count = 7'd0;
    cyc();
    drain_start = 1'b0;
    check("em_done", 64'(drain_done), 64'd1);
    check("em_valid", 64'(out_valid), 64'd0);
    cyc();
    check("em_done_end", 64'(drain_done), 64'd0);

    // reset mid-drain
    for (int i = 0; i < 4; i++) wr_mem(i, 64'h300 + 64'(i));
    drain_start = 1'b1;
    drain_count = 7'd4;
    read_num_in = 32'h77;
    cyc();
    drain_start = 1'b0;
    cyc();
    check("rm_b1", out_x0, 64'h301);
    #2;
    rst = 1'b1;
    #1;
    check("rm_valid", 64'(out_valid), 64'd0);
    check("rm_stall", 64'(stall), 64'd0);
    check("rm_x0", out_x0, 64'd0);
    check("rm_tag", 64'(out_read_num), 64'd0);
    check("rm_last", 64'(out_last), 64'd0);
    cyc();
    rst = 1'b0;
    rd_en = 1'b1;
    rd_addr = 7'd5;
    cyc();
    rd_en = 1'b0;
    check("rm_rd_valid", 64'(rd_valid), 64'd1);
    check("rm_rd_hit", 64'(rd_hit), 64'd0);
    cyc();
    check("rm_idle_done", 64'(drain_done), 64'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
